crossbar_wrr_lock_arbiter: RTL and testbench

Weighted round-robin N×M crossbar arbiter with packet locking and output back-pressure. It sits in front of the crossbar datapath, where several requesters compete for output ports.

- Each output port arbitrates independently among the inputs that target it.
- A multi-beat packet holds its output until its last beat.
- Each input gets up to `weight[i]` consecutive packets per round-robin turn.
- A global mode selects fixed priority instead of round-robin.

---
 rtl/crossbar_wrr_lock_arbiter_pkg.sv | 27 ++
 rtl/crossbar_wrr_lock_arbiter_ppe.sv | 48 ++++
 rtl/crossbar_wrr_lock_arbiter.sv | 164 ++++++++++++++++
 tb/tb_crossbar_wrr_lock_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_wrr_lock_arbiter_pkg.sv
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared types and width helpers for the crossbar weighted
//               round-robin arbiter with packet locking.
//               Contents:
//                 arb_state_t - per-output arbitration state (IDLE/LOCKED)
//                 idx_width() - index width for an N-entry vector (min 1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Width of an index into an n-entry vector; never returns 0 so that
  // degenerate sizes still give legal declarations.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crossbar_wrr_lock_arbiter_ppe.sv
// ============================================================================
// Module      : programmable_priority_encode
// Description : Picks the first set request at or after priority_pointer,
//               wrapping modulo N_REQ.
// Ports       : req              in  N_REQ           request vector
//               priority_pointer in  clog2(N_REQ)    search start index
//               valid            out 1               any request found
//               grant_onehot     out N_REQ           one-hot winner
//               grant_id         out clog2(N_REQ)    winner index
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module programmable_priority_encode
  import arbiter_pkg::*;
#(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] priority_pointer,
  output logic                     valid,
  output logic [N_REQ-1:0]         grant_onehot,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int IW = idx_width(N_REQ);

  logic [IW-1:0] w_idx;

  // N_REQ is a power of two, so the IW-bit add wraps naturally.
  always_comb begin
    valid        = 1'b0;
    grant_onehot = '0;
    grant_id     = '0;
    w_idx        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = priority_pointer + k[IW-1:0];
      if (!valid && req[w_idx]) begin
        valid               = 1'b1;
        grant_onehot[w_idx] = 1'b1;
        grant_id            = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crossbar_wrr_lock_arbiter.sv
// ============================================================================
// Module      : crossbar_wrr_lock_arbiter
// Description : N x M crossbar arbiter. Each output independently runs a
//               weighted round-robin (or fixed-priority) selection among the
//               inputs targeting it, and holds a multi-beat packet's owner
//               until its last beat. Grants are combinational.
// Ports       : clk                  in  1           clock
//               rst                  in  1           async reset, active low
//               req                  in  NI          per-input beat request
//               req_out_port         in  NI x log2NO target output per input
//               req_last             in  NI          beat is last of packet
//               weight               in  NI x W      packets per turn (0 = 1)
//               fixed_prio_mode      in  1           input 0 highest priority
//               out_ready            in  NO          output accepts a beat
//               grant                out NI          input beat transfers
//               grant_out_port_wise  out NO          output transfers a beat
//               detailed_grant       out NO x NI     one-hot grant per output
//               granted_requester_id out NO x log2NI winner per output
//               locked               out NO          output held by a packet
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crossbar_wrr_lock_arbiter
  import arbiter_pkg::*;
#(
  parameter int N_IN_PORTS  = 8,
  parameter int N_OUT_PORTS = 8,
  parameter int W_WEIGHT    = 4,
  parameter int LOCK_EN     = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [N_IN_PORTS-1:0]                              req,
  input  logic [N_IN_PORTS-1:0][$clog2(N_OUT_PORTS)-1:0]     req_out_port,
  input  logic [N_IN_PORTS-1:0]                              req_last,
  input  logic [N_IN_PORTS-1:0][W_WEIGHT-1:0]                weight,
  input  logic                                               fixed_prio_mode,
  input  logic [N_OUT_PORTS-1:0]                             out_ready,
  output logic [N_IN_PORTS-1:0]                              grant,
  output logic [N_OUT_PORTS-1:0]                             grant_out_port_wise,
  output logic [N_OUT_PORTS-1:0][N_IN_PORTS-1:0]             detailed_grant,
  output logic [N_OUT_PORTS-1:0][$clog2(N_IN_PORTS)-1:0]     granted_requester_id,
  output logic [N_OUT_PORTS-1:0]                             locked
);

  localparam int IW = idx_width(N_IN_PORTS);
  localparam int OW = idx_width(N_OUT_PORTS);

  for (genvar o = 0; o < N_OUT_PORTS; o++) begin : g_out
    localparam logic [OW-1:0] c_port = OW'(o);

    arb_state_t            r_state;
    logic [IW-1:0]         r_owner;
    logic [IW-1:0]         r_ptr;
    logic [W_WEIGHT-1:0]   r_pkt_cnt;

    logic [N_IN_PORTS-1:0] w_cand;
    logic [N_IN_PORTS-1:0] w_owner_mask;
    logic [N_IN_PORTS-1:0] w_elig;
    logic [N_IN_PORTS-1:0] w_onehot;
    logic [IW-1:0]         w_search_start;
    logic [IW-1:0]         w_id;
    logic                  w_valid;
    logic                  w_xfer;
    logic                  w_last;
    logic [W_WEIGHT:0]     w_cnt;
    logic [W_WEIGHT:0]     w_limit;

    always_comb begin
      w_cand = '0;
      for (int i = 0; i < N_IN_PORTS; i++) begin
        w_cand[i] = req[i] && (req_out_port[i] == c_port);
      end
      w_owner_mask          = '0;
      w_owner_mask[r_owner] = 1'b1;
    end

    // While locked only the owner may win; an owner that drops req or
    // retargets simply leaves the output idle without releasing the lock.
    assign w_elig         = (r_state == ARB_LOCKED) ? (w_cand & w_owner_mask) : w_cand;
    assign w_search_start = fixed_prio_mode ? '0 : r_ptr;

    programmable_priority_encode #(
      .N_REQ (N_IN_PORTS)
    ) u_ppe (
      .req              (w_elig),
      .priority_pointer (w_search_start),
      .valid            (w_valid),
      .grant_onehot     (w_onehot),
      .grant_id         (w_id)
    );

    // rst gating keeps grants off while reset is held, even with req high.
    assign w_xfer = w_valid && out_ready[o] && rst;
    assign w_last = (LOCK_EN == 0) ? 1'b1 : |(w_onehot & req_last);

    assign detailed_grant[o]       = w_xfer ? w_onehot : '0;
    assign grant_out_port_wise[o]  = w_xfer;
    assign granted_requester_id[o] = w_xfer ? w_id : '0;
    assign locked[o]               = (r_state == ARB_LOCKED);

    // Consecutive completions by the pointer holder extend its turn.
    assign w_cnt   = (w_id == r_ptr) ? ({1'b0, r_pkt_cnt} + 1'b1)
                                     : {{W_WEIGHT{1'b0}}, 1'b1};
    assign w_limit = (weight[w_id] == '0) ? {{W_WEIGHT{1'b0}}, 1'b1}
                                          : {1'b0, weight[w_id]};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state   <= ARB_IDLE;
        r_owner   <= '0;
        r_ptr     <= '0;
        r_pkt_cnt <= '0;
      end else begin
        if (w_xfer) begin
          if ((r_state == ARB_IDLE) && !w_last) begin
            r_state <= ARB_LOCKED;
            r_owner <= w_id;
          end else if ((r_state == ARB_LOCKED) && w_last) begin
            r_state <= ARB_IDLE;
          end
        end

        if (fixed_prio_mode) begin
          r_ptr     <= '0;
          r_pkt_cnt <= '0;
        end else if (w_xfer && w_last) begin
          if (w_cnt >= w_limit) begin
            r_ptr     <= w_id + 1'b1;
            r_pkt_cnt <= '0;
          end else begin
            r_ptr     <= w_id;
            r_pkt_cnt <= w_cnt[W_WEIGHT-1:0];
          end
        end
      end
    end

    a_onehot_grant : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(detailed_grant[o]))
      else $warning("detailed_grant[%0d] not one-hot: %b", o, detailed_grant[o]);

    a_no_grant_unready : assert property (@(posedge clk) disable iff (!rst)
        !out_ready[o] |-> !grant_out_port_wise[o])
      else $warning("grant on output %0d while out_ready low", o);
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < N_OUT_PORTS; o++) begin
      grant = grant | detailed_grant[o];
    end
  end

  for (genvar i = 0; i < N_IN_PORTS; i++) begin : g_in
    a_grant_has_req : assert property (@(posedge clk) disable iff (!rst)
        grant[i] |-> req[i])
      else $warning("grant on input %0d without req", i);
  end

endmodule

`default_nettype wire

// File: tb/tb_crossbar_wrr_lock_arbiter.sv
// ============================================================================
// Module      : tb_crossbar_wrr_lock_arbiter
// Description : Directed self-checking bench for crossbar_wrr_lock_arbiter
//               with 4 inputs and 4 outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crossbar_wrr_lock_arbiter;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int WW = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NI-1:0]           req;
  logic [NI-1:0][1:0]      req_out_port;
  logic [NI-1:0]           req_last;
  logic [NI-1:0][WW-1:0]   weight;
  logic                    fixed_prio_mode;
  logic [NO-1:0]           out_ready;
  logic [NI-1:0]           grant;
  logic [NO-1:0]           grant_out_port_wise;
  logic [NO-1:0][NI-1:0]   detailed_grant;
  logic [NO-1:0][1:0]      granted_requester_id;
  logic [NO-1:0]           locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crossbar_wrr_lock_arbiter #(
    .N_IN_PORTS  (NI),
    .N_OUT_PORTS (NO),
    .W_WEIGHT    (WW),
    .LOCK_EN     (1)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req                  (req),
    .req_out_port         (req_out_port),
    .req_last             (req_last),
    .weight               (weight),
    .fixed_prio_mode      (fixed_prio_mode),
    .out_ready            (out_ready),
    .grant                (grant),
    .grant_out_port_wise  (grant_out_port_wise),
    .detailed_grant       (detailed_grant),
    .granted_requester_id (granted_requester_id),
    .locked               (locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst             = 1'b0;
    req             = '0;
    req_last        = '0;
    req_out_port    = '0;
    out_ready       = '1;
    fixed_prio_mode = 1'b0;
    weight          = {4'd1, 4'd1, 4'd1, 4'd1};
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    req             = '1;
    req_last        = '0;
    req_out_port    = '0;
    out_ready       = '1;
    fixed_prio_mode = 1'b0;
    weight          = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int c = 0; c < 2; c++) begin
      #3;
      checks++;
      if (grant !== 4'b0000) begin
        errors++; $display("FAIL reset_grant cycle %0d: got %b expected 0000", c, grant);
      end
      checks++;
      if (detailed_grant !== 16'h0000) begin
        errors++; $display("FAIL reset_detailed cycle %0d: got %h expected 0000", c, detailed_grant);
      end
      checks++;
      if (locked !== 4'b0000) begin
        errors++; $display("FAIL reset_locked cycle %0d: got %b expected 0000", c, locked);
      end
      tick();
    end
    req = '0;
    #3;
    checks++;
    if (granted_requester_id !== 8'h00 || grant_out_port_wise !== 4'b0000) begin
      errors++; $display("FAIL reset_id: got id %h gpw %b expected 00 0000",
                         granted_requester_id, grant_out_port_wise);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    apply_reset();
    req_out_port = '0;
    req_last     = '1;
    req          = '1;
    for (int c = 0; c < 5; c++) begin
      exp_g = 4'(1 << (c % 4));
      #3;
      checks++;
      if (grant !== exp_g) begin
        errors++; $display("FAIL rr_grant cycle %0d: got %b expected %b", c, grant, exp_g);
      end
      checks++;
      if (granted_requester_id[0] !== 2'(c % 4)) begin
        errors++; $display("FAIL rr_id cycle %0d: got %0d expected %0d", c,
                           granted_requester_id[0], c % 4);
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_locking();
    logic [3:0] t_req  [4] = '{4'b0010, 4'b0011, 4'b0011, 4'b0001};
    logic [3:0] t_last [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0001};
    logic [3:0] t_g    [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic       t_lk   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] t_id   [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    apply_reset();
    req_out_port[0] = 2'd2;
    req_out_port[1] = 2'd2;
    for (int c = 0; c < 4; c++) begin
      req      = t_req[c];
      req_last = t_last[c];
      #3;
      checks++;
      if (grant !== t_g[c] || grant_out_port_wise !== 4'b0100) begin
        errors++; $display("FAIL lock_grant cycle %0d: got %b/%b expected %b/0100",
                           c, grant, grant_out_port_wise, t_g[c]);
      end
      checks++;
      if (locked[2] !== t_lk[c]) begin
        errors++; $display("FAIL lock_state cycle %0d: got %b expected %b", c, locked[2], t_lk[c]);
      end
      checks++;
      if (granted_requester_id[2] !== t_id[c]) begin
        errors++; $display("FAIL lock_id cycle %0d: got %0d expected %0d", c,
                           granted_requester_id[2], t_id[c]);
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_weighting();
    logic [1:0] t_id [8] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0};
    apply_reset();
    weight = {4'd3, 4'd1, 4'd1, 4'd1};
    // Single beat from input 2 moves ptr[1] from 0 to 3.
    req_out_port[2] = 2'd1;
    req             = 4'b0100;
    req_last        = 4'b0100;
    #3;
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL wrr_prime: got %b expected 0100", grant);
    end
    tick();
    req_out_port[0] = 2'd1;
    req_out_port[3] = 2'd1;
    req             = 4'b1001;
    req_last        = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #3;
      checks++;
      if (granted_requester_id[1] !== t_id[c] || grant !== 4'(1 << t_id[c])) begin
        errors++; $display("FAIL wrr_order cycle %0d: got id %0d grant %b expected id %0d",
                           c, granted_requester_id[1], grant, t_id[c]);
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_back_pressure();
    logic [3:0] t_req  [7] = '{4'b0100, 4'b0110, 4'b0110, 4'b0010, 4'b0110, 4'b0110, 4'b0010};
    logic [3:0] t_last [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0010};
    logic       t_rdy  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] t_g    [7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0010};
    logic       t_lk   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      req          = t_req[c];
      req_last     = t_last[c];
      out_ready[0] = t_rdy[c];
      #3;
      checks++;
      if (grant !== t_g[c] || grant_out_port_wise[0] !== (t_g[c] != 4'b0000)) begin
        errors++; $display("FAIL bp_grant cycle %0d: got %b/%b expected %b",
                           c, grant, grant_out_port_wise, t_g[c]);
      end
      checks++;
      if (locked[0] !== t_lk[c]) begin
        errors++; $display("FAIL bp_locked cycle %0d: got %b expected %b", c, locked[0], t_lk[c]);
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_parallel();
    apply_reset();
    req_out_port = {2'd3, 2'd2, 2'd1, 2'd0};
    req          = '1;
    req_last     = '1;
    #3;
    checks++;
    if (grant !== 4'b1111 || grant_out_port_wise !== 4'b1111) begin
      errors++; $display("FAIL par_grant: got %b/%b expected 1111/1111", grant, grant_out_port_wise);
    end
    checks++;
    if (granted_requester_id !== {2'd3, 2'd2, 2'd1, 2'd0}) begin
      errors++; $display("FAIL par_id: got %h expected e4", granted_requester_id);
    end
    tick();
    // ptr[0] advanced to 1 after input 0 completed there.
    req_out_port = '0;
    #3;
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL par_ptr_after: got %b expected 0010", grant);
    end
    tick();
    req = '0;
  endtask

  task automatic test_fixed_prio();
    apply_reset();
    req_out_port[2] = 2'd3;
    req             = 4'b0100;
    req_last        = 4'b1111;
    tick();
    req_out_port[0] = 2'd3;
    req_out_port[3] = 2'd3;
    req             = 4'b1001;
    fixed_prio_mode = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      checks++;
      if (grant !== 4'b0001 || granted_requester_id[3] !== 2'd0) begin
        errors++; $display("FAIL fp_grant cycle %0d: got %b id %0d expected 0001 id 0",
                           c, grant, granted_requester_id[3]);
      end
      tick();
    end
    fixed_prio_mode = 1'b0;
    #3;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL fp_ptr_held: got %b expected 0001", grant);
    end
    tick();
    #3;
    checks++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL fp_rr_resume: got %b expected 1000", grant);
    end
    tick();
    req = '0;
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    req      = 4'b0010;
    req_last = 4'b0010;
    #3;
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL rmp_first: got %b expected 0010", grant);
    end
    tick();
    req      = 4'b0100;
    req_last = 4'b0000;
    #3;
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL rmp_start: got %b expected 0100", grant);
    end
    tick();
    #1;
    checks++;
    if (locked[0] !== 1'b1) begin
      errors++; $display("FAIL rmp_locked: got %b expected 1", locked[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (locked[0] !== 1'b0 || grant !== 4'b0000) begin
      errors++; $display("FAIL rmp_async: got locked %b grant %b expected 0 0000", locked[0], grant);
    end
    tick();
    rst      = 1'b1;
    req      = 4'b0101;
    req_last = 4'b0101;
    #3;
    checks++;
    if (grant !== 4'b0001 || locked[0] !== 1'b0) begin
      errors++; $display("FAIL rmp_ptr_cleared: got %b locked %b expected 0001 0", grant, locked[0]);
    end
    tick();
    #3;
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL rmp_next: got %b expected 0100", grant);
    end
    tick();
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_locking();
    test_weighting();
    test_back_pressure();
    test_parallel();
    test_fixed_prio();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
